// File: rtl/serial_alu_sequencer.sv
// -----------------------------------------------------------------------------
// serial_alu_sequencer
//
// Drives a one-bit ALU slice LSB first, one bit per clock, to execute a
// WIDTH-bit operation. The slice's carry-out is fed back as the carry-in of
// the next bit. The result is assembled bit by bit and returned together with
// carry, zero and overflow flags.
//
// Optional feature macro: SERIAL_ALU_OVERFLOW_EN
//   defined   : rsp_overflow = carry-in XOR carry-out of the MSB slice (mode 0)
//   undefined : no overflow logic, rsp_overflow tied to 0
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_a, req_b         WIDTH-bit operands
//   req_opcode           {mode, operation[2:0]}; mode 0 arithmetic, 1 logic
//   alu_a, alu_b         current operand bits to the slice
//   alu_mode             slice mode
//   alu_operation        slice operation
//   alu_cin              slice carry-in
//   alu_out, alu_carry   slice result bit and carry-out (combinational return)
//   rsp_valid/rsp_ready  response handshake
//   rsp_result           assembled WIDTH-bit result
//   rsp_carry            final carry (0 for logic ops)
//   rsp_zero             1 when every result bit is 0
//   rsp_overflow         signed overflow (0 for logic ops or when disabled)
// -----------------------------------------------------------------------------
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_opcode,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_mode,
    output logic [2:0]       alu_operation,
    output logic             alu_cin,
    input  logic             alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow
);

    localparam int                IDX_W     = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [3:0]        OP_SUB    = 4'b0011;
    localparam logic [3:0]        OP_SHL    = 4'b1101;
    localparam logic [2:0]        OP_PASS_A = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic [2:0]       operation_q, operation_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             any_one_q, any_one_d;   // OR of result bits seen so far
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             is_shl;
    logic [IDX_W-1:0] prev_idx;

    assign is_shl   = ({mode_q, operation_q} == OP_SHL);
    assign prev_idx = bit_idx_q - IDX_W'(1);

    // Slice drive: combinational from registers while running, idle pattern otherwise.
    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_a         = 1'b0;
        alu_b         = 1'b0;
        alu_mode      = 1'b1;
        alu_operation = OP_PASS_A;
        alu_cin       = 1'b0;
        if (state_q == RUN) begin
            alu_b         = b_q[bit_idx_q];
            alu_mode      = mode_q;
            alu_operation = operation_q;
            alu_cin       = carry_q;
            if (is_shl) begin
                // Shift left is a pass-A of the operand delayed by one bit position.
                alu_operation = OP_PASS_A;
                alu_a         = (bit_idx_q == '0) ? 1'b0 : a_q[prev_idx];
            end else begin
                alu_a = a_q[bit_idx_q];
            end
        end
    end

`ifdef SERIAL_ALU_OVERFLOW_EN
    logic overflow_q, overflow_d;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        operation_d = operation_q;
        bit_idx_d   = bit_idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        any_one_d   = any_one_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
        overflow_d  = overflow_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    mode_d      = req_opcode[3];
                    operation_d = req_opcode[2:0];
                    bit_idx_d   = '0;
                    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                    carry_d     = (req_opcode == OP_SUB);
                    result_d    = '0;
                    any_one_d   = 1'b0;
                    rsp_carry_d = 1'b0;
                    rsp_zero_d  = 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
                    overflow_d  = 1'b0;
`endif
                    req_ready_d = 1'b0;
                    state_d     = RUN;
                end
            end

            RUN: begin
                result_d[bit_idx_q] = alu_out;
                any_one_d           = any_one_q | alu_out;
                carry_d             = alu_carry;
                bit_idx_d           = bit_idx_q + IDX_W'(1);
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d   = '0;
                    rsp_carry_d = ~mode_q & alu_carry;
                    rsp_zero_d  = ~(any_one_q | alu_out);
`ifdef SERIAL_ALU_OVERFLOW_EN
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    overflow_d  = ~mode_q & (alu_cin ^ alu_carry);
`endif
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            operation_q <= '0;
            bit_idx_q   <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            any_one_q   <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            operation_q <= operation_d;
            bit_idx_q   <= bit_idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            any_one_q   <= any_one_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef SERIAL_ALU_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
`ifdef SERIAL_ALU_OVERFLOW_EN
    assign rsp_overflow = overflow_q;
`else
    assign rsp_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_sequencer
//
// Self-checking bench: a behavioural one-bit ALU slice closes the loop around
// the sequencer, and a word-level arithmetic reference model provides the
// expected result and flags for directed and randomized requests.
// -----------------------------------------------------------------------------
module tb_serial_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_opcode;
    logic         alu_a;
    logic         alu_b;
    logic         alu_mode;
    logic [2:0]   alu_operation;
    logic         alu_cin;
    logic         alu_out;
    logic         alu_carry;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    logic         rsp_overflow;

    int checks = 0;
    int errors = 0;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_opcode    (req_opcode),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_mode      (alu_mode),
        .alu_operation (alu_operation),
        .alu_cin       (alu_cin),
        .alu_out       (alu_out),
        .alu_carry     (alu_carry),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .rsp_overflow  (rsp_overflow)
    );

    always #5 clk = ~clk;

    // One-bit ALU slice. In logic mode the carry output is deliberately
    // non-zero for some inputs so the sequencer must mask it.
    always_comb begin
        alu_out   = 1'b0;
        alu_carry = 1'b0;
        if (!alu_mode) begin
            case (alu_operation)
                3'b000: begin
                    alu_out   = alu_a ^ alu_b ^ alu_cin;
                    alu_carry = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
                end
                3'b011: begin
                    alu_out   = alu_a ^ ~alu_b ^ alu_cin;
                    alu_carry = (alu_a & ~alu_b) | (alu_a & alu_cin) | (~alu_b & alu_cin);
                end
                default: alu_out = alu_a;
            endcase
        end else begin
            alu_carry = alu_a & alu_b;
            case (alu_operation)
                3'b000:  alu_out = alu_a & alu_b;
                3'b001:  alu_out = alu_a | alu_b;
                3'b010:  alu_out = alu_a ^ alu_b;
                3'b111:  alu_out = alu_a;
                default: alu_out = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference model.
    task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          output logic [W-1:0] res, output logic c, output logic z, output logic ovf);
        logic [W:0] sum;
        res = '0;
        c   = 1'b0;
        ovf = 1'b0;
        case (op)
            4'b0000: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[W-1:0];
                c   = sum[W];
                ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'b0011: begin
                sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                res = sum[W-1:0];
                c   = sum[W];
                ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            4'b1101: res = a << 1;
            4'b1000: res = a & b;
            4'b1001: res = a | b;
            4'b1010: res = a ^ b;
            default: res = '0;
        endcase
        z = (res == '0);
`ifndef SERIAL_ALU_OVERFLOW_EN
        ovf = 1'b0;
`endif
    endtask

    // Issue one request and check the full transaction. Called #1 after a rising edge, in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                         input int hold);
        logic [W-1:0] e_res;
        logic         e_c, e_z, e_ovf;
        logic [W-1:0] s_res;
        logic         s_c, s_z, s_ovf;
        int           lat;
        string        t;
        ref_op(a, b, op, e_res, e_c, e_z, e_ovf);
        t = $sformatf("op%h_%h_%h", op, a, b);

        check({t, " ready_idle"}, 32'(req_ready), 32'd1);
        req_a      = a;
        req_b      = b;
        req_opcode = op;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({t, " ready_run"}, 32'(req_ready), 32'd0);
        check({t, " cin_bit0"}, 32'(alu_cin), 32'(op == 4'b0011));

        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({t, " latency"}, 32'(lat), 32'(W));
        if (!rsp_valid) return;

        check({t, " result"},   32'(rsp_result),   32'(e_res));
        check({t, " carry"},    32'(rsp_carry),    32'(e_c));
        check({t, " zero"},     32'(rsp_zero),     32'(e_z));
        check({t, " overflow"}, 32'(rsp_overflow), 32'(e_ovf));

        s_res = rsp_result;
        s_c   = rsp_carry;
        s_z   = rsp_zero;
        s_ovf = rsp_overflow;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 2 == 0);
            req_a     = 8'($urandom);
            req_opcode = 4'b0000;
            @(posedge clk);
            #1;
            check({t, " hold_valid"},  32'(rsp_valid), 32'd1);
            check({t, " hold_ready"},  32'(req_ready), 32'd0);
            check({t, " hold_stable"}, {23'd0, s_ovf, s_z, s_c, s_res},
                  {23'd0, rsp_overflow, rsp_zero, rsp_carry, rsp_result});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({t, " post_valid"}, 32'(rsp_valid), 32'd0);
        check({t, " post_ready"}, 32'(req_ready), 32'd1);
        check({t, " idle_drive"}, {27'd0, alu_mode, alu_operation, alu_cin},
              {27'd0, 1'b1, 3'b111, 1'b0});
    endtask

    logic [3:0] op_tab [6];

    initial begin
        op_tab = '{4'b0000, 4'b0011, 4'b1101, 4'b1000, 4'b1001, 4'b1010};
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset outputs", {21'd0, rsp_overflow, rsp_zero, rsp_carry, rsp_result}, 32'd0);
        check("reset drive", {25'd0, alu_mode, alu_operation, alu_a, alu_b, alu_cin},
              {25'd0, 1'b1, 3'b111, 3'b000});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        do_op(8'h3C, 8'h0A, 4'b0000, 0);
        do_op(8'h05, 8'h05, 4'b0011, 0);
        do_op(8'hFF, 8'h01, 4'b0000, 1);
        do_op(8'h7F, 8'h01, 4'b0000, 0);
        do_op(8'h81, 8'h00, 4'b1101, 0);
        do_op(8'hF0, 8'h3C, 4'b1000, 5);
        do_op(8'h80, 8'h01, 4'b0011, 0);

        // Reset in the middle of a run (after three bits processed).
        req_a      = 8'h55;
        req_b      = 8'h33;
        req_opcode = 4'b0000;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun ready", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort drive", {28'd0, alu_mode, alu_operation}, {28'd0, 1'b1, 3'b111});
        check("abort result", 32'(rsp_result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(8'h12, 8'h34, 4'b0000, 0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), op_tab[$urandom_range(0, 5)],
                  int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
